// File: rtl/inst_rom_arb_pkg.sv
// Shared definitions for the instruction-ROM arbiter: ROM widths, master
// indices, FSM states and the default lock length.
package inst_rom_arb_pkg;

    localparam int unsigned ROM_ADDR_W      = 32;
    localparam int unsigned ROM_DATA_W      = 32;
    localparam int unsigned LOCK_MAX_DEFAULT = 16;

    // Master index, also used as the round-robin priority pointer value.
    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_e;

    // IDLE: normal round-robin; LOCKED: requester 1 owns the ROM port.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Word-aligned byte address check on the two low address bits.
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

    // Pointer value of the master that is not the given one.
    function automatic mst_e other_mst(input mst_e m);
        return (m == MST_M0) ? MST_M1 : MST_M0;
    endfunction

endpackage

// File: rtl/inst_rom_arb_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to ptr_i.
module rr_arb2
    import inst_rom_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  mst_e       ptr_i,
    output logic [1:0] gnt_o
);

    // One-hot grant from the request pair and the priority pointer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_i == MST_M0) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/inst_rom_arb.sv
// Arbitrates the instruction-ROM data port between the core memory stage
// (M0) and the program loader/debug port (M1). M1 may lock the port for up
// to LOCK_MAX consecutive beats; each accepted beat answers one cycle later.
module inst_rom_arb
    import inst_rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ROM_ADDR_W,
    parameter int unsigned DATA_W   = ROM_DATA_W,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic              m0_err_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic              m1_err_o,

    output logic [DATA_W-1:0] rdata_o,

    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [DATA_W-1:0] rom_wr_data_o,
    output logic              rom_wr_en_o,
    input  logic [DATA_W-1:0] rom_rd_data_i
);

    localparam int unsigned     CNT_W   = $clog2(LOCK_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    state_e            state_q, state_d;
    mst_e              ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              err0_q,    err0_d;
    logic              err1_q,    err1_d;

    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_aligned;
    logic              acc0, acc1, acc_any;
    logic [CNT_W-1:0]  cnt_next;

    rr_arb2 u_rr_arb2 (
        .req_i (m1_req_i ? (m0_req_i ? 2'b11 : 2'b10) : (m0_req_i ? 2'b01 : 2'b00)),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    // Grant: round-robin in IDLE, M1-only in LOCKED, nothing while in reset.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE:   gnt = arb_gnt;
                ST_LOCKED: gnt = {m1_req_i, 1'b0};
                default:   gnt = 2'b00;
            endcase
        end
    end

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];
    assign acc0     = m0_req_i & gnt[0];
    assign acc1     = m1_req_i & gnt[1];
    assign acc_any  = acc0 | acc1;

    // Steer the granted requester onto the ROM port; zeros when idle.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[0]) begin
            sel_we    = m0_we_i;
            sel_addr  = m0_addr_i;
            sel_wdata = m0_wdata_i;
        end else if (gnt[1]) begin
            sel_we    = m1_we_i;
            sel_addr  = m1_addr_i;
            sel_wdata = m1_wdata_i;
        end
    end

    assign sel_aligned   = is_aligned(sel_addr[1:0]);
    assign rom_addr_o    = sel_addr;
    assign rom_wr_data_o = sel_wdata;
    assign rom_wr_en_o   = acc_any & sel_we & sel_aligned;

    // Lock counter value if this beat extends the lock; saturates at LOCK_MAX.
    assign cnt_next = (state_q == ST_IDLE) ? CNT_W'(1) :
                      (cnt_q >= CNT_MAX)   ? CNT_MAX   : cnt_q + CNT_W'(1);

    // Next state: pointer rotation, lock entry/exit and the one-cycle response.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rvalid0_d = acc0;
        rvalid1_d = acc1;
        err0_d    = acc0 & ~sel_aligned;
        err1_d    = acc1 & ~sel_aligned;

        if (state_q == ST_IDLE && m0_req_i && m1_req_i && acc_any) begin
            ptr_d = other_mst(ptr_q);
        end

        if (acc1 && m1_lock_i) begin
            cnt_d = cnt_next;
            if (cnt_next >= CNT_MAX) begin
                // Lock exhausted: hand the next contended cycle to M0.
                state_d = ST_IDLE;
                ptr_d   = MST_M0;
            end else begin
                state_d = ST_LOCKED;
            end
        end else if (acc1 && state_q == ST_LOCKED) begin
            state_d = ST_IDLE;
        end

        if (acc_any && !sel_we && sel_aligned) begin
            rdata_d = rom_rd_data_i;
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= MST_M0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    // A response still pending when reset rises is dropped in that same cycle.
    assign m0_rvalid_o = rvalid0_q & ~rst;
    assign m1_rvalid_o = rvalid1_q & ~rst;
    assign m0_err_o    = err0_q & ~rst;
    assign m1_err_o    = err1_q & ~rst;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_inst_rom_arb.sv
// Directed bench for inst_rom_arb: a vector table for single-cycle behaviour
// plus hand sequences for the forced lock release and reset mid-lock.
module tb_inst_rom_arb;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata;
    logic [31:0] rdata;
    logic [31:0] rom_addr, rom_wr_data, rom_rd_data;
    logic        rom_wr_en;

    logic [31:0] rom [0:63];

    int n_checks = 0;
    int n_pass   = 0;

    inst_rom_arb dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req_i      (m0_req),
        .m0_we_i       (m0_we),
        .m0_addr_i     (m0_addr),
        .m0_wdata_i    (m0_wdata),
        .m0_gnt_o      (m0_gnt),
        .m0_rvalid_o   (m0_rvalid),
        .m0_err_o      (m0_err),
        .m1_req_i      (m1_req),
        .m1_we_i       (m1_we),
        .m1_lock_i     (m1_lock),
        .m1_addr_i     (m1_addr),
        .m1_wdata_i    (m1_wdata),
        .m1_gnt_o      (m1_gnt),
        .m1_rvalid_o   (m1_rvalid),
        .m1_err_o      (m1_err),
        .rdata_o       (rdata),
        .rom_addr_o    (rom_addr),
        .rom_wr_data_o (rom_wr_data),
        .rom_wr_en_o   (rom_wr_en),
        .rom_rd_data_i (rom_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM: combinational read, write on the clock edge.
    assign rom_rd_data = rom[rom_addr[7:2]];
    always @(posedge clk) begin
        if (rom_wr_en) rom[rom_wr_data === 32'hx ? 0 : rom_addr[7:2]] <= rom_wr_data;
    end

    typedef struct {
        logic        rst;
        logic        m0_req, m0_we;
        logic [31:0] m0_addr, m0_wdata;
        logic        m1_req, m1_we, m1_lock;
        logic [31:0] m1_addr, m1_wdata;
        logic        e_m0_gnt, e_m1_gnt, e_wr_en;
        logic        e_m0_rv, e_m0_err, e_m1_rv, e_m1_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mv(
        input logic r,
        input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic q1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1,
        input logic g0, input logic g1, input logic we,
        input logic v0, input logic e0, input logic v1, input logic e1,
        input logic [31:0] rd);
        vec_t v;
        v.rst = r;
        v.m0_req = q0; v.m0_we = w0; v.m0_addr = a0; v.m0_wdata = d0;
        v.m1_req = q1; v.m1_we = w1; v.m1_lock = l1; v.m1_addr = a1; v.m1_wdata = d1;
        v.e_m0_gnt = g0; v.e_m1_gnt = g1; v.e_wr_en = we;
        v.e_m0_rv = v0; v.e_m0_err = e0; v.e_m1_rv = v1; v.e_m1_err = e1;
        v.e_rdata = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance to just after the next rising edge and drive all inputs.
    task automatic drive(
        input logic r,
        input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic q1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        rst = r;
        m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    endtask

    logic prev_g0, prev_g1, eg0, eg1;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
        repeat (2) @(posedge clk);

        // Reset, first read, round-robin, short lock, misaligned accesses.
        vecs.push_back(mv(1, 0,0,32'h0,0,          0,0,0,32'h0,0,           0,0,0, 0,0,0,0, 32'h0));
        vecs.push_back(mv(1, 1,0,32'h8,0,          0,0,0,32'h0,0,           0,0,0, 0,0,0,0, 32'h0));
        vecs.push_back(mv(0, 1,0,32'h8,0,          0,0,0,32'h0,0,           1,0,0, 0,0,0,0, 32'h0));
        vecs.push_back(mv(0, 0,0,32'h0,0,          0,0,0,32'h0,0,           0,0,0, 1,0,0,0, 32'h1000_0002));
        vecs.push_back(mv(0, 1,0,32'h0,0,          1,0,0,32'h4,0,           1,0,0, 0,0,0,0, 32'h1000_0002));
        vecs.push_back(mv(0, 1,0,32'h0,0,          1,0,0,32'h4,0,           0,1,0, 1,0,0,0, 32'h1000_0000));
        vecs.push_back(mv(0, 1,0,32'h0,0,          1,0,0,32'h4,0,           1,0,0, 0,0,1,0, 32'h1000_0001));
        vecs.push_back(mv(0, 1,0,32'h0,0,          1,0,0,32'h4,0,           0,1,0, 1,0,0,0, 32'h1000_0000));
        vecs.push_back(mv(0, 1,0,32'h0,0,          1,0,0,32'h4,0,           1,0,0, 0,0,1,0, 32'h1000_0001));
        vecs.push_back(mv(0, 1,0,32'h0,0,          1,0,0,32'h4,0,           0,1,0, 1,0,0,0, 32'h1000_0000));
        vecs.push_back(mv(0, 1,0,32'h0,0,          1,0,0,32'h4,0,           1,0,0, 0,0,1,0, 32'h1000_0001));
        vecs.push_back(mv(0, 1,0,32'h10,0,         1,1,1,32'h10,32'hDEADBEEF, 0,1,1, 1,0,0,0, 32'h1000_0000));
        vecs.push_back(mv(0, 1,0,32'h10,0,         1,1,1,32'h10,32'hDEADBEEF, 0,1,1, 0,0,1,0, 32'h1000_0000));
        vecs.push_back(mv(0, 1,0,32'h10,0,         1,1,1,32'h10,32'hDEADBEEF, 0,1,1, 0,0,1,0, 32'h1000_0000));
        vecs.push_back(mv(0, 1,0,32'h10,0,         1,1,0,32'h10,32'hDEADBEEF, 0,1,1, 0,0,1,0, 32'h1000_0000));
        vecs.push_back(mv(0, 1,0,32'h10,0,         0,0,0,32'h0,0,           1,0,0, 0,0,1,0, 32'h1000_0000));
        vecs.push_back(mv(0, 0,0,32'h0,0,          0,0,0,32'h0,0,           0,0,0, 1,0,0,0, 32'hDEADBEEF));
        vecs.push_back(mv(0, 1,1,32'h6,32'h12345678, 0,0,0,32'h0,0,         1,0,0, 0,0,0,0, 32'hDEADBEEF));
        vecs.push_back(mv(0, 0,0,32'h0,0,          0,0,0,32'h0,0,           0,0,0, 1,1,0,0, 32'hDEADBEEF));
        vecs.push_back(mv(0, 0,0,32'h0,0,          1,0,0,32'h5,0,           0,1,0, 0,0,0,0, 32'hDEADBEEF));
        vecs.push_back(mv(0, 0,0,32'h0,0,          0,0,0,32'h0,0,           0,0,0, 0,0,1,1, 32'hDEADBEEF));
        vecs.push_back(mv(0, 1,0,32'h4,0,          0,0,0,32'h0,0,           1,0,0, 0,0,0,0, 32'hDEADBEEF));
        vecs.push_back(mv(0, 0,0,32'h0,0,          0,0,0,32'h0,0,           0,0,0, 1,0,0,0, 32'h1000_0001));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].m0_req, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_wdata,
                  vecs[i].m1_req, vecs[i].m1_we, vecs[i].m1_lock, vecs[i].m1_addr, vecs[i].m1_wdata);
            @(negedge clk);
            check($sformatf("v%0d m0_gnt", i),    {31'b0, m0_gnt},    {31'b0, vecs[i].e_m0_gnt});
            check($sformatf("v%0d m1_gnt", i),    {31'b0, m1_gnt},    {31'b0, vecs[i].e_m1_gnt});
            check($sformatf("v%0d rom_wr_en", i), {31'b0, rom_wr_en}, {31'b0, vecs[i].e_wr_en});
            check($sformatf("v%0d m0_rvalid", i), {31'b0, m0_rvalid}, {31'b0, vecs[i].e_m0_rv});
            check($sformatf("v%0d m0_err", i),    {31'b0, m0_err},    {31'b0, vecs[i].e_m0_err});
            check($sformatf("v%0d m1_rvalid", i), {31'b0, m1_rvalid}, {31'b0, vecs[i].e_m1_rv});
            check($sformatf("v%0d m1_err", i),    {31'b0, m1_err},    {31'b0, vecs[i].e_m1_err});
            check($sformatf("v%0d rdata", i),     rdata,              vecs[i].e_rdata);
        end

        // Long lock: released after 16 beats, M0 wins the next cycle, M1 relocks.
        prev_g0 = 1'b0;
        prev_g1 = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            drive(0, (c > 1), 0, 32'h0, 0, 1, 0, 1, 32'h0, 0);
            @(negedge clk);
            eg0 = (c == 17);
            eg1 = (c != 17);
            check($sformatf("lock c%0d m0_gnt", c),    {31'b0, m0_gnt},    {31'b0, eg0});
            check($sformatf("lock c%0d m1_gnt", c),    {31'b0, m1_gnt},    {31'b0, eg1});
            check($sformatf("lock c%0d m0_rvalid", c), {31'b0, m0_rvalid}, {31'b0, prev_g0});
            check($sformatf("lock c%0d m1_rvalid", c), {31'b0, m1_rvalid}, {31'b0, prev_g1});
            prev_g0 = eg0;
            prev_g1 = eg1;
        end
        // M1 idle while locked keeps the lock; an unlocked beat releases it.
        drive(0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check("hold m0_gnt", {31'b0, m0_gnt}, 32'd0);
        check("hold m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        drive(0, 1, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0);
        @(negedge clk);
        check("unlock m1_gnt", {31'b0, m1_gnt}, 32'd1);
        check("unlock m0_gnt", {31'b0, m0_gnt}, 32'd0);
        drive(0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check("after unlock m0_gnt", {31'b0, m0_gnt}, 32'd1);
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check("after unlock m0_rvalid", {31'b0, m0_rvalid}, 32'd1);

        // Reset right after a locked M1 beat: response dropped, back to IDLE/M0.
        drive(0, 1, 0, 32'h0, 0, 1, 0, 0, 32'h4, 0);
        @(negedge clk);
        check("rst seq contend m0_gnt", {31'b0, m0_gnt}, 32'd1);
        drive(0, 0, 0, 32'h0, 0, 1, 0, 1, 32'h4, 0);
        @(negedge clk);
        check("rst seq lock m1_gnt", {31'b0, m1_gnt}, 32'd1);
        drive(1, 1, 0, 32'h0, 0, 1, 0, 1, 32'h4, 0);
        @(negedge clk);
        check("rst seq m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        check("rst seq m0_gnt", {31'b0, m0_gnt}, 32'd0);
        check("rst seq m1_gnt", {31'b0, m1_gnt}, 32'd0);
        drive(0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h4, 0);
        @(negedge clk);
        check("post rst m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("post rst m1_gnt", {31'b0, m1_gnt}, 32'd0);
        check("post rst m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        check("post rst rdata", rdata, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check("post rst m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
        check("post rst read rdata", rdata, 32'h1000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
